// File: rtl/acmd12_cmd_arbiter.sv
// acmd12_cmd_arbiter: arbitrates driver commands and Auto CMD12 onto one command engine.
// Auto CMD12 support is built only when SDHCI_ACMD12_EN is defined.
module acmd12_cmd_arbiter #(
  parameter int MinGapCycles = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        sd_clk_en_i,
  input  logic        host_cmd_valid_i,
  output logic        host_cmd_ready_o,
  input  logic [5:0]  host_cmd_index_i,
  input  logic [31:0] host_cmd_arg_i,
  input  logic [1:0]  host_cmd_rsp_type_i,
  input  logic [1:0]  host_cmd_chk_i,
  input  logic        acmd12_req_i,
  output logic        eng_start_o,
  output logic [5:0]  eng_index_o,
  output logic [31:0] eng_arg_o,
  output logic [1:0]  eng_rsp_type_o,
  output logic [1:0]  eng_chk_o,
  input  logic        eng_done_i,
  input  logic [3:0]  eng_err_i,
  output logic        host_done_o,
  output logic        host_abort_o,
  output logic [3:0]  host_err_o,
  output logic        acmd_done_o,
  output logic [7:0]  acmd_err_status_o,
  input  logic [7:0]  acmd_err_clr_i
);
`ifdef SDHCI_ACMD12_EN
  localparam bit AcmdEn = 1'b1;
`else
  localparam bit AcmdEn = 1'b0;
`endif
  localparam int GapW = $clog2(MinGapCycles + 2);

  typedef enum logic [1:0] {IDLE, GAP, ISSUE, WAIT_RSP} state_t;
  state_t r_state, w_state_nxt;

  logic            r_host_pend, r_acmd_pend, r_cur_acmd;
  logic [5:0]      r_h_index;
  logic [31:0]     r_h_arg;
  logic [1:0]      r_h_rsp, r_h_chk;
  logic [GapW-1:0] r_gap_cnt;
  logic            r_start, r_host_done, r_abort, r_acmd_done;
  logic [3:0]      r_host_err;
  logic [7:0]      r_status;
  logic            w_hs, w_req, w_grant, w_done, w_err;
  logic            w_acmd_fin, w_host_fin, w_abort, w_cancel;
  logic [7:0]      w_set;

  assign w_hs       = host_cmd_valid_i & ~r_host_pend;
  assign w_req      = AcmdEn & acmd12_req_i & ~r_acmd_pend;
  assign w_grant    = (r_state == ISSUE) & sd_clk_en_i;
  assign w_done     = (r_state == WAIT_RSP) & eng_done_i;
  assign w_err      = |eng_err_i;
  assign w_acmd_fin = w_done & r_cur_acmd;
  assign w_host_fin = w_done & ~r_cur_acmd;
  // A failed CMD12 discards the queued driver command; a failed driver command cancels CMD12.
  assign w_abort    = w_acmd_fin & w_err & r_host_pend;
  assign w_cancel   = w_host_fin & w_err & r_acmd_pend;
  assign w_set      = {w_abort, 2'b00, w_acmd_fin ? eng_err_i : 4'b0000, w_cancel};

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:     w_state_nxt = (r_host_pend | r_acmd_pend) ? ISSUE : IDLE;
      ISSUE:    w_state_nxt = sd_clk_en_i ? WAIT_RSP : ISSUE;
      WAIT_RSP: w_state_nxt = eng_done_i ? GAP : WAIT_RSP;
      GAP:      w_state_nxt = (r_gap_cnt == '0) ? IDLE : GAP;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state        <= IDLE;
      r_host_pend    <= 1'b0;
      r_acmd_pend    <= 1'b0;
      r_cur_acmd     <= 1'b0;
      r_h_index      <= '0;
      r_h_arg        <= '0;
      r_h_rsp        <= '0;
      r_h_chk        <= '0;
      r_gap_cnt      <= '0;
      r_start        <= 1'b0;
      eng_index_o    <= '0;
      eng_arg_o      <= '0;
      eng_rsp_type_o <= '0;
      eng_chk_o      <= '0;
      r_host_done    <= 1'b0;
      r_host_err     <= '0;
      r_abort        <= 1'b0;
      r_acmd_done    <= 1'b0;
      r_status       <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_hs) begin
        r_h_index <= host_cmd_index_i;
        r_h_arg   <= host_cmd_arg_i;
        r_h_rsp   <= host_cmd_rsp_type_i;
        r_h_chk   <= host_cmd_chk_i;
      end
      r_host_pend <= w_hs | (r_host_pend & ~w_host_fin & ~w_abort);
      r_acmd_pend <= w_req | (r_acmd_pend & ~w_acmd_fin & ~w_cancel);
      if (w_grant) begin
        r_cur_acmd     <= r_acmd_pend;
        eng_index_o    <= r_acmd_pend ? 6'd12 : r_h_index;
        eng_arg_o      <= r_acmd_pend ? 32'd0 : r_h_arg;
        eng_rsp_type_o <= r_acmd_pend ? 2'b11 : r_h_rsp;
        eng_chk_o      <= r_acmd_pend ? 2'b11 : r_h_chk;
      end
      r_start     <= w_grant;
      r_gap_cnt   <= w_done ? GapW'(MinGapCycles) :
                     ((r_state == GAP) && sd_clk_en_i && (r_gap_cnt != '0)) ? r_gap_cnt - 1'b1 : r_gap_cnt;
      r_host_done <= w_host_fin;
      r_host_err  <= w_host_fin ? eng_err_i : 4'b0000;
      r_abort     <= w_abort;
      r_acmd_done <= w_acmd_fin | w_cancel;
      r_status    <= (r_status & ~acmd_err_clr_i) | w_set;
    end
  end

  assign host_cmd_ready_o  = ~r_host_pend;
  assign eng_start_o       = r_start;
  assign host_done_o       = r_host_done;
  assign host_err_o        = r_host_err;
  assign host_abort_o      = r_abort;
  assign acmd_done_o       = AcmdEn & r_acmd_done;
  assign acmd_err_status_o = AcmdEn ? r_status : 8'h00;
endmodule

// File: doc/acmd12_cmd_arbiter.md
ACMD12_CMD_ARBITER -- requirements
Module: acmd12_cmd_arbiter

Interface
REQ-001 SHALL have parameter: MinGapCycles, default 2, SD clock enable pulses the CMD line stays idle between a command's completion and the next issue.
REQ-002 SHALL have a single clock and an asynchronous, active-low reset: clk_i  input  1  system clock.
REQ-003 rst_ni  input  1  asynchronous active-low reset.
REQ-004 sd_clk_en_i  input  1  one-cycle strobe per SD clock rising edge.
REQ-005 host_cmd_valid_i / host_cmd_ready_o  in/out  1/1  driver command handshake.
REQ-006 host_cmd_index_i, host_cmd_arg_i, host_cmd_rsp_type_i, host_cmd_chk_i  input  6/32/2/2  index, argument, response type, {index_chk, crc_chk}.
REQ-007 acmd12_req_i  input  1  pulse from data path: last block done, Auto CMD12 needed.
REQ-008 eng_start_o  output  1  one-cycle start pulse to command engine.
REQ-009 eng_index_o, eng_arg_o, eng_rsp_type_o, eng_chk_o  output  6/32/2/2  command fields, held stable from start until eng_done_i.
REQ-010 eng_done_i, eng_err_i  input  1/4  completion pulse; {index, end_bit, crc, timeout} errors valid with done.
REQ-011 host_done_o, host_abort_o  output  1/1  driver command completed / discarded unissued.
REQ-012 host_err_o  output  4  {index, end_bit, crc, timeout}, valid with host_done_o.
REQ-013 acmd_done_o  output  1  Auto CMD12 completed or cancelled pulse.
REQ-014 acmd_err_status_o  output  8  Auto CMD12 error status register image; acmd_err_clr_i  input  8  write-1-to-clear.

Function
REQ-015 FSM states SHALL be IDLE, GAP, ISSUE, WAIT_RSP.
REQ-016 host_cmd_ready_o SHALL equal !host_pend; a handshake latches the host fields and sets host_pend.
REQ-017 acmd12_req_i SHALL set acmd_pend; a request while acmd_pend is set is ignored.
REQ-018 In IDLE with any pending request, transition to ISSUE; ISSUE waits for sd_clk_en_i, then pulses eng_start_o and enters WAIT_RSP.
REQ-019 Grant in ISSUE SHALL favour acmd_pend (simultaneous arrival: CMD12 first); a host command already granted (ISSUE passed) is never pre-empted.
REQ-020 CMD12 fields SHALL be index 12, argument 0, response type 2'b11, eng_chk_o 2'b11.
REQ-021 On eng_done_i in WAIT_RSP: report result, clear that request's pend flag, enter GAP; GAP counts MinGapCycles sd_clk_en_i pulses then returns to IDLE.
REQ-022 Host result: host_done_o pulse, host_err_o = eng_err_i.
REQ-023 CMD12 result: acmd_done_o pulse; eng_err_i bits {timeout,crc,end,index} set acmd_err_status_o bits 1,2,3,4 (sticky).
REQ-024 CMD12 completes with nonzero error while host_pend: host command SHALL NOT issue; host_abort_o pulses, host_pend clears, acmd_err_status_o bit 7 set, no host_err_o.
REQ-025 Host command completes with nonzero error while acmd_pend: CMD12 SHALL NOT issue; acmd_pend clears, acmd_err_status_o bit 0 set, acmd_done_o pulses.
REQ-026 Bits 5,6 of acmd_err_status_o SHALL read 0; clear via acmd_err_clr_i takes effect next cycle, a same-cycle set wins.
REQ-027 Abort/cancel decisions SHALL occur in the eng_done_i cycle; the GAP phase still follows.

Reset
REQ-028 All outputs SHALL be 0 after reset except host_cmd_ready_o = 1; FSM = IDLE, pend flags and status cleared.
REQ-029 Reset asserted mid-command SHALL drop all pending requests without any done/abort pulse.

Configuration
REQ-030 Macro SDHCI_ACMD12_EN defined: full behaviour above.
REQ-031 Macro undefined: acmd12_req_i ignored, acmd_done_o and acmd_err_status_o tied 0, host path unchanged.

Verification
REQ-032 acmd12_req_i and host valid same cycle, both OK -> eng_start_o index 12 first, then index 0 after 2 sd_clk_en pulses idle; status 0x00.
REQ-033 Same, CMD12 returns crc+index errors -> host_abort_o, no second start, acmd_err_status_o = 0x94, host_err_o never asserted.
REQ-034 Host valid 3 cycles before acmd12_req_i, host returns crc+index -> host_err_o = 4'b1010, no CMD12 start, acmd_err_status_o = 0x01.
REQ-035 Host first, OK -> CMD12 issued afterwards, acmd_done_o, status 0x00; acmd_err_clr_i 0xFF after 0x94 -> status 0x00.
REQ-036 rst_ni low during WAIT_RSP -> outputs reset values, no further eng_start_o.
